// File: rtl/scroll_msg_engine.sv
// -----------------------------------------------------------------------------
// scroll_msg_engine
//
// Message engine for the scrolling seven-segment display. In program mode,
// hex nibbles taken from the switch word are appended to a circular message
// buffer. In display mode, a DIGITS-wide window scrolls across the stored
// message at a programmable rate, with direction and pause control.
//
// Ports:
//   clk     in   system clock (single domain)
//   reset   in   asynchronous active-high reset
//   prog    in   level, 1 = program mode requested
//   enter   in   1-cycle pulse, commits sw (program mode only)
//   clear   in   1-cycle pulse, empties the message (program mode only)
//   dir     in   0 = scroll left (read pointer increments), 1 = scroll right
//   pause   in   level, freezes scrolling and holds the prescaler
//   sw      in   entry word, most significant nibble written first
//   digits  out  nibble window, top nibble = leftmost digit
//   blank   out  per-digit blanking, MSB = leftmost digit, 1 = dark
//   led     out  mirrors sw while programming, 0 otherwise
//   len     out  number of nibbles stored
//   full    out  last enter was rejected for lack of space (program mode)
// -----------------------------------------------------------------------------
module scroll_msg_engine #(
    parameter int DIGITS   = 8,
    parameter int DEPTH    = 64,
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 100000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prog,
    input  logic                     enter,
    input  logic                     clear,
    input  logic                     dir,
    input  logic                     pause,
    input  logic [DATA_W-1:0]        sw,
    output logic [4*DIGITS-1:0]      digits,
    output logic [DIGITS-1:0]        blank,
    output logic [DATA_W-1:0]        led,
    output logic [$clog2(DEPTH):0]   len,
    output logic                     full
);

    localparam int NIB    = DATA_W / 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LEN_W  = PTR_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    // One extra bit so len+NIB cannot overflow before the capacity compare.
    localparam logic [LEN_W:0]    ROOM_LIMIT = (LEN_W + 1)'(DEPTH);
    localparam logic [LEN_W:0]    NIB_EXT    = (LEN_W + 1)'(NIB);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROG   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic [3:0]          mem_r    [DEPTH];
    logic [3:0]          mem_nx_s [DEPTH];
    logic [LEN_W-1:0]    len_r, len_nx_s;
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_nx_s;
    logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_nx_s;
    logic [TICK_W-1:0]   presc_r, presc_nx_s;
    logic                full_r, full_nx_s;
    logic                wr_en_s;
    logic [4*DIGITS-1:0] digits_r, win_digits_s;
    logic [DIGITS-1:0]   blank_r, win_blank_s;

    // Advance a pointer by one, wrapping at the message length (not DEPTH).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr,
                                                  input logic [LEN_W-1:0] n);
        if (({1'b0, ptr} + LEN_W'(1)) == n) begin
            wrap_inc = {PTR_W{1'b0}};
        end else begin
            wrap_inc = ptr + PTR_W'(1);
        end
    endfunction

    // Step a pointer back by one, wrapping from 0 to length-1.
    function automatic logic [PTR_W-1:0] wrap_dec(input logic [PTR_W-1:0] ptr,
                                                  input logic [LEN_W-1:0] n);
        if (ptr == {PTR_W{1'b0}}) begin
            wrap_dec = PTR_W'(n - LEN_W'(1));
        end else begin
            wrap_dec = ptr - PTR_W'(1);
        end
    endfunction

    // Next-state and datapath control for the IDLE/PROG/SCROLL machine.
    always_comb begin
        state_nx_s  = state_r;
        len_nx_s    = len_r;
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        presc_nx_s  = presc_r;
        full_nx_s   = full_r;
        wr_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (prog) begin
                    state_nx_s = ST_PROG;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PROG: begin
                // clear has priority over a simultaneous enter
                if (clear) begin
                    len_nx_s    = {LEN_W{1'b0}};
                    wr_ptr_nx_s = {PTR_W{1'b0}};
                    rd_ptr_nx_s = {PTR_W{1'b0}};
                    full_nx_s   = 1'b0;
                end else if (prog && enter) begin
                    if (({1'b0, len_r} + NIB_EXT) <= ROOM_LIMIT) begin
                        wr_en_s     = 1'b1;
                        len_nx_s    = len_r + LEN_W'(NIB);
                        wr_ptr_nx_s = wr_ptr_r + PTR_W'(NIB);
                        full_nx_s   = 1'b0;
                    end else begin
                        full_nx_s   = 1'b1;
                    end
                end else begin
                    len_nx_s = len_r;
                end
                // Leaving program mode restarts the scroll from the message head.
                if (!prog) begin
                    if (len_nx_s != {LEN_W{1'b0}}) begin
                        state_nx_s = ST_SCROLL;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                    rd_ptr_nx_s = {PTR_W{1'b0}};
                    presc_nx_s  = {TICK_W{1'b0}};
                    full_nx_s   = 1'b0;
                end else begin
                    state_nx_s = ST_PROG;
                end
            end
            ST_SCROLL: begin
                if (prog) begin
                    state_nx_s = ST_PROG;
                end else if (!pause) begin
                    if (presc_r == TICK_LAST) begin
                        presc_nx_s = {TICK_W{1'b0}};
                        if (dir) begin
                            rd_ptr_nx_s = wrap_dec(rd_ptr_r, len_r);
                        end else begin
                            rd_ptr_nx_s = wrap_inc(rd_ptr_r, len_r);
                        end
                    end else begin
                        presc_nx_s = presc_r + TICK_W'(1);
                    end
                end else begin
                    presc_nx_s = presc_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Memory contents after this cycle, with the incoming nibbles bypassed so
    // the registered window can reflect an accepted enter immediately.
    always_comb begin
        logic [PTR_W-1:0] widx_v;
        widx_v = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            mem_nx_s[i] = mem_r[i];
        end
        for (int n = 0; n < NIB; n++) begin
            widx_v = wr_ptr_r + PTR_W'(n);
            if (wr_en_s) begin
                mem_nx_s[widx_v] = sw[DATA_W-4-4*n +: 4];
            end else begin
                mem_nx_s[widx_v] = mem_r[widx_v];
            end
        end
    end

    // Window to be shown after this cycle, built from next-state values.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        idx_v        = {PTR_W{1'b0}};
        win_digits_s = {(4*DIGITS){1'b0}};
        win_blank_s  = {DIGITS{1'b1}};
        case (state_nx_s)
            ST_PROG: begin
                // Newest nibble at the rightmost digit; j counts from the right.
                for (int j = 0; j < DIGITS; j++) begin
                    if (LEN_W'(j) < len_nx_s) begin
                        idx_v = PTR_W'(len_nx_s - LEN_W'(j) - LEN_W'(1));
                        win_digits_s[4*j +: 4] = mem_nx_s[idx_v];
                        win_blank_s[j]         = 1'b0;
                    end else begin
                        win_blank_s[j]         = 1'b1;
                    end
                end
            end
            ST_SCROLL: begin
                // Walk from the read pointer, wrapping at len so short
                // messages repeat across the window.
                idx_v = rd_ptr_nx_s;
                for (int k = 0; k < DIGITS; k++) begin
                    win_digits_s[4*(DIGITS-1-k) +: 4] = mem_nx_s[idx_v];
                    win_blank_s[DIGITS-1-k]           = 1'b0;
                    idx_v = wrap_inc(idx_v, len_nx_s);
                end
            end
            default: begin
                win_blank_s = {DIGITS{1'b1}};
            end
        endcase
    end

    // State, pointers, prescaler, message store and registered window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            len_r    <= {LEN_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            presc_r  <= {TICK_W{1'b0}};
            full_r   <= 1'b0;
            digits_r <= {(4*DIGITS){1'b0}};
            blank_r  <= {DIGITS{1'b1}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'h0;
            end
        end else begin
            state_r  <= state_nx_s;
            len_r    <= len_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            presc_r  <= presc_nx_s;
            full_r   <= full_nx_s;
            digits_r <= win_digits_s;
            blank_r  <= win_blank_s;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_nx_s[i];
            end
        end
    end

    assign digits = digits_r;
    assign blank  = blank_r;
    assign len    = len_r;
    assign full   = full_r;
    // led tracks the switches combinationally so the user sees them at once.
    assign led    = (state_r == ST_PROG) ? sw : {DATA_W{1'b0}};

endmodule

// File: tb/tb_scroll_msg_engine.sv
module tb_scroll_msg_engine;

    localparam int DIGITS   = 4;
    localparam int DEPTH    = 8;
    localparam int DATA_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int NIB      = DATA_W / 4;

    logic        clk = 1'b0;
    logic        reset, prog, enter, clear, dir, pause;
    logic [7:0]  sw;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [7:0]  led;
    logic [3:0]  len;
    logic        full;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 program, 2 scroll
    int         m_mode;
    logic [3:0] m_msg[$];
    int         m_rd;
    int         m_cnt;
    logic       m_full;

    always #5 clk = ~clk;

    scroll_msg_engine #(
        .DIGITS(DIGITS), .DEPTH(DEPTH), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .prog(prog), .enter(enter), .clear(clear),
        .dir(dir), .pause(pause), .sw(sw), .digits(digits), .blank(blank),
        .led(led), .len(len), .full(full)
    );

    task automatic model_reset();
        m_mode = 0;
        m_msg.delete();
        m_rd   = 0;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    // Apply one clock edge of the specification's rules to the model.
    task automatic model_clock();
        int n;
        logic [3:0] nib;
        n = m_msg.size();
        case (m_mode)
            0: if (prog) m_mode = 1;
            1: begin
                if (clear) begin
                    m_msg.delete();
                    m_rd = 0;
                    m_full = 1'b0;
                end else if (prog && enter) begin
                    if (n + NIB <= DEPTH) begin
                        for (int q = 0; q < NIB; q++) begin
                            nib = 4'(sw >> (4 * (NIB - 1 - q)));
                            m_msg.push_back(nib);
                        end
                        m_full = 1'b0;
                    end else begin
                        m_full = 1'b1;
                    end
                end
                if (!prog) begin
                    m_mode = (m_msg.size() > 0) ? 2 : 0;
                    m_rd = 0;
                    m_cnt = 0;
                    m_full = 1'b0;
                end
            end
            default: begin
                if (prog) m_mode = 1;
                else if (!pause) begin
                    if (m_cnt == TICK_DIV - 1) begin
                        m_cnt = 0;
                        m_rd = dir ? (m_rd + n - 1) % n : (m_rd + 1) % n;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [15:0] exp_digits();
        logic [15:0] d;
        int n;
        d = 16'h0000;
        n = m_msg.size();
        if (m_mode == 1) begin
            for (int j = 0; j < DIGITS; j++)
                if (j < n) d[4*j +: 4] = m_msg[n-1-j];
        end else if (m_mode == 2) begin
            for (int k = 0; k < DIGITS; k++)
                d[4*(DIGITS-1-k) +: 4] = m_msg[(m_rd + k) % n];
        end
        return d;
    endfunction

    function automatic logic [3:0] exp_blank();
        logic [3:0] b;
        int n;
        b = 4'b1111;
        n = m_msg.size();
        if (m_mode == 1) begin
            for (int j = 0; j < DIGITS; j++)
                if (j < n) b[j] = 1'b0;
        end else if (m_mode == 2) begin
            b = 4'b0000;
        end
        return b;
    endfunction

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic enter_word(input logic [7:0] w);
        sw = w;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    // Window expected after s left steps of message 12345678.
    function automatic logic [15:0] left_window(input int s);
        logic [15:0] d;
        for (int k = 0; k < DIGITS; k++)
            d[4*(DIGITS-1-k) +: 4] = 4'(((s + k) % 8) + 1);
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1; prog = 1'b0; enter = 1'b0; clear = 1'b0;
        dir = 1'b0; pause = 1'b0; sw = 8'h00;
        model_reset();
        #12;
        if (blank !== 4'b1111) begin $display("FAIL reset_blank: got %b expected 1111", blank); n_errors++; end
        n_checks++;
        if (digits !== 16'h0000) begin $display("FAIL reset_digits: got %h expected 0000", digits); n_errors++; end
        n_checks++;
        if (len !== 4'd0 || full !== 1'b0 || led !== 8'h00) begin
            $display("FAIL reset_len_full_led: got %0d %b %h expected 0 0 00", len, full, led); n_errors++;
        end
        n_checks++;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            sw = 8'($urandom);
            enter = 1'($urandom_range(0, 1));
            tick();
            if (blank !== 4'b1111 || len !== 4'd0 || led !== 8'h00) begin
                $display("FAIL idle_hold: got blank %b len %0d led %h expected 1111 0 00", blank, len, led);
                n_errors++;
            end
            n_checks++;
        end
        enter = 1'b0;
    endtask

    task automatic test_prog_entry();
        prog = 1'b1;
        tick();
        if (blank !== 4'b1111 || len !== 4'd0) begin
            $display("FAIL prog_empty: got blank %b len %0d expected 1111 0", blank, len); n_errors++;
        end
        n_checks++;
        sw = 8'hA5; #1;
        if (led !== 8'hA5) begin $display("FAIL led_follow: got %h expected a5", led); n_errors++; end
        n_checks++;
        enter_word(8'h12);
        if (len !== 4'd2 || digits !== 16'h0012 || blank !== 4'b1100) begin
            $display("FAIL first_entry: got len %0d digits %h blank %b expected 2 0012 1100", len, digits, blank);
            n_errors++;
        end
        n_checks++;
        enter_word(8'h34);
        if (len !== 4'd4 || digits !== 16'h1234 || blank !== 4'b0000) begin
            $display("FAIL second_entry: got len %0d digits %h blank %b expected 4 1234 0000", len, digits, blank);
            n_errors++;
        end
        n_checks++;
        if (led !== 8'h34 || full !== 1'b0) begin
            $display("FAIL prog_led_full: got %h %b expected 34 0", led, full); n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_overflow();
        enter_word(8'h56);
        enter_word(8'h78);
        if (len !== 4'd8 || digits !== 16'h5678 || full !== 1'b0) begin
            $display("FAIL fill_to_depth: got len %0d digits %h full %b expected 8 5678 0", len, digits, full);
            n_errors++;
        end
        n_checks++;
        enter_word(8'h9A);
        if (len !== 4'd8 || full !== 1'b1 || digits !== 16'h5678) begin
            $display("FAIL overflow_reject: got len %0d full %b digits %h expected 8 1 5678", len, full, digits);
            n_errors++;
        end
        n_checks++;
        sw = 8'hBC; clear = 1'b1; enter = 1'b1;
        tick();
        clear = 1'b0; enter = 1'b0;
        if (len !== 4'd0 || full !== 1'b0 || blank !== 4'b1111 || digits !== 16'h0000) begin
            $display("FAIL clear_wins: got len %0d full %b blank %b digits %h expected 0 0 1111 0000",
                     len, full, blank, digits);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_scroll_left();
        logic [15:0] prev;
        enter_word(8'h12); enter_word(8'h34); enter_word(8'h56); enter_word(8'h78);
        dir = 1'b0; pause = 1'b0; prog = 1'b0;
        tick();
        if (digits !== 16'h1234 || blank !== 4'b0000 || led !== 8'h00) begin
            $display("FAIL scroll_entry: got %h %b %h expected 1234 0000 00", digits, blank, led); n_errors++;
        end
        n_checks++;
        for (int s = 1; s <= 8; s++) begin
            prev = left_window(s - 1);
            ticks(TICK_DIV - 1);
            if (digits !== prev) begin
                $display("FAIL left_hold step %0d: got %h expected %h", s, digits, prev); n_errors++;
            end
            n_checks++;
            tick();
            if (digits !== left_window(s)) begin
                $display("FAIL left_step %0d: got %h expected %h", s, digits, left_window(s)); n_errors++;
            end
            n_checks++;
        end
    endtask

    task automatic test_dir_pause_short();
        prog = 1'b1;
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        enter_word(8'h12);
        prog = 1'b0;
        tick();
        if (digits !== 16'h1212) begin $display("FAIL short_repeat: got %h expected 1212", digits); n_errors++; end
        n_checks++;
        ticks(TICK_DIV);
        if (digits !== 16'h2121) begin $display("FAIL short_left_wrap: got %h expected 2121", digits); n_errors++; end
        n_checks++;
        dir = 1'b1;
        ticks(TICK_DIV);
        if (digits !== 16'h1212) begin $display("FAIL right_step: got %h expected 1212", digits); n_errors++; end
        n_checks++;
        ticks(2);
        pause = 1'b1;
        ticks(20);
        if (digits !== 16'h1212) begin $display("FAIL pause_freeze: got %h expected 1212", digits); n_errors++; end
        n_checks++;
        pause = 1'b0;
        tick();
        if (digits !== 16'h1212) begin $display("FAIL pause_presc_hold: got %h expected 1212", digits); n_errors++; end
        n_checks++;
        tick();
        if (digits !== 16'h2121) begin $display("FAIL right_wrap_zero: got %h expected 2121", digits); n_errors++; end
        n_checks++;
        dir = 1'b0;
    endtask

    task automatic test_reset_mid_scroll();
        prog = 1'b1;
        tick();
        enter_word(8'h34);
        prog = 1'b0;
        ticks(6);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        if (blank !== 4'b1111 || digits !== 16'h0000 || len !== 4'd0 || full !== 1'b0 || led !== 8'h00) begin
            $display("FAIL mid_reset: got blank %b digits %h len %0d full %b led %h expected 1111 0000 0 0 00",
                     blank, digits, len, full, led);
            n_errors++;
        end
        n_checks++;
        @(posedge clk); #2;
        reset = 1'b0;
        prog = 1'b1; sw = 8'h3C;
        tick();
        if (led !== 8'h3C || blank !== 4'b1111) begin
            $display("FAIL reprog_empty: got led %h blank %b expected 3c 1111", led, blank); n_errors++;
        end
        n_checks++;
        prog = 1'b0;
        tick();
        enter = 1'b1; tick(); enter = 1'b0;
        if (blank !== 4'b1111 || len !== 4'd0 || led !== 8'h00) begin
            $display("FAIL empty_exit_idle: got blank %b len %0d led %h expected 1111 0 00", blank, len, led);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 29) == 0) prog = ~prog;
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            enter = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 24) == 0);
            sw = 8'($urandom);
            tick();
            if (digits !== exp_digits() || blank !== exp_blank()) begin
                $display("FAIL rand_window cycle %0d: got %h/%b expected %h/%b",
                         c, digits, blank, exp_digits(), exp_blank());
                n_errors++;
            end
            n_checks++;
            if (len !== 4'(m_msg.size()) || full !== m_full) begin
                $display("FAIL rand_len_full cycle %0d: got %0d/%b expected %0d/%b",
                         c, len, full, m_msg.size(), m_full);
                n_errors++;
            end
            n_checks++;
            if (led !== ((m_mode == 1) ? sw : 8'h00)) begin
                $display("FAIL rand_led cycle %0d: got %h expected %h", c, led, (m_mode == 1) ? sw : 8'h00);
                n_errors++;
            end
            n_checks++;
        end
        enter = 1'b0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prog_entry();
        test_overflow();
        test_scroll_left();
        test_dir_pause_short();
        test_reset_mid_scroll();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
